read_guard: RTL and testbench
=============================

Name: read_guard

Overview:
- Passive AXI read-channel monitor; the read-side counterpart of the write transaction guard.
- Taps the AR and R handshakes between master and slave without ever driving them.
- Tracks up to MaxRdTxns outstanding reads, enforces per-transaction latency budgets and burst-length/RLAST correctness, and flags unexpected R beats.
- On any violation it latches a reset request, pulses an interrupt and captures diagnostic info for the register file.

Parameters:
- MaxRdTxns, 4, number of tracking slots (>=1).
- IdWidth, 4, AXI ID width.
- AddrWidth, 32, AXI address width.
- CntWidth, 16, budget/latency counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous and active-high.
- ar_valid_i  in  1  AR valid.
- ar_ready_i  in  1  AR ready.
- ar_id_i  in  IdWidth  AR ID.
- ar_addr_i  in  AddrWidth  AR address.
- ar_len_i  in  8  AR burst length (beats-1).
- r_valid_i  in  1  R valid.
- r_ready_i  in  1  R ready.
- r_id_i  in  IdWidth  R ID.
- r_last_i  in  1  R last.
- budget_i  in  CntWidth  per-beat cycle budget, sampled at AR handshake.
- reset_clear_i  in  1  clears the latched reset request.
- full_o  out  1  all slots busy; upstream gates AR with it.
- reset_req_o  out  1  sticky reset request.
- irq_o  out  1  one-cycle interrupt pulse.
- irq_cause_o  out  4  {overflow, last_err, unwanted, timeout}.
- irq_id_o  out  IdWidth  ID of the offending transaction.
- irq_addr_o  out  AddrWidth  address of the offending transaction (0 if none).
- latency_o  out  CntWidth  latency of the last retired read.
- latency_valid_o  out  1  one-cycle pulse when latency_o updates.

Behaviour:
- Reset: all slots free; every output is 0.
- Slot fields: busy, id, addr, beats_left (8b), rank, budget counter, elapsed counter.
- Allocate on (ar_valid_i && ar_ready_i && !full_o && !reset_req_o):
  - Use the lowest-index free slot; beats_left = ar_len_i.
  - Budget counter = budget_i*(ar_len_i+1), saturated at 2^CntWidth-1.
  - elapsed = 0.
  - rank = count of busy slots with the same ID, minus 1 if a same-ID retire occurs in the same cycle.
- A slot is head of its ID when rank==0. R beats are matched to the head of r_id_i only; reads are in order within an ID.
- On R handshake (r_valid_i && r_ready_i):
  - No busy head slot with r_id_i -> unwanted error.
  - beats_left==0 && r_last_i -> retire the slot.
  - beats_left!=0 && !r_last_i -> beats_left decrements.
  - Otherwise (early or missing last) -> last_err.
- Retire:
  - Slot freed.
  - All other busy slots with the same ID decrement rank.
  - Next cycle: latency_o = elapsed+1 (saturating), latency_valid_o=1. Latency equals the cycle count from the AR handshake to the RLAST handshake.
- Every busy slot, every cycle: budget counter decrements (floor 0), elapsed increments (saturating).
- Timeout: a busy slot with budget counter==0 that is not retiring this cycle. Retire wins over timeout in the same cycle.
- Overflow: an AR handshake while full_o=1. A retire in the same cycle does not prevent overflow.
- Error response, registered (outputs change the cycle after detection):
  - irq_cause_o = OR of all causes detected that cycle.
  - irq_id_o/irq_addr_o taken from the lowest-index timed-out slot if any. Otherwise irq_id_o = r_id_i for unwanted/last_err, or ar_id_i for overflow; irq_addr_o = head slot addr for last_err, else 0.
  - irq_o pulses 1 cycle; reset_req_o set; all slots cleared.
- While reset_req_o=1: no allocation, no detection; capture registers hold.
  - reset_clear_i clears reset_req_o next cycle.
  - A new error in the same cycle as reset_clear_i keeps reset_req_o set.
- budget_i=0: the counter loads 0, so the slot times out on the next cycle unless it retires in that cycle.

Test Plan:
- AR id=2 len=3 budget_i=10 at cycle 0; R beats at cycles 5-8, last at cycle 8 -> latency_valid_o at cycle 9 with latency_o=8; no irq.
- AR id=1 len=0 budget_i=4; no R -> timeout at cycle 5 (budget counter 0); irq_o pulse at cycle 6 with cause=0001, irq_id_o=1, irq_addr_o=AR address; reset_req_o stays 1 until reset_clear_i.
- R handshake id=7 with nothing outstanding -> cause=0010, irq_id_o=7, irq_addr_o=0.
- AR id=3 len=1, then R id=3 with r_last_i=1 on the first beat -> cause=0100, irq_addr_o=AR address.
- Two ARs id=5 (len 0, then len 2), R id=5 last=1 -> first slot retires, second becomes head. Then three beats with last on the third -> retire; no errors.
- MaxRdTxns=4 slots filled, fifth AR handshake -> cause=1000. Also fill with one slot retiring in the same cycle -> overflow still flagged.

Source files
------------

// File: rtl/read_guard.sv
// +--------------------------------------------------------------------------+
// | read_guard : passive AXI read-channel monitor (latency, RLAST, ID check) |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module read_guard #(
    parameter int MaxRdTxns = 4,
    parameter int IdWidth   = 4,
    parameter int AddrWidth = 32,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ar_valid_i,
    input  logic                 ar_ready_i,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    input  logic                 r_valid_i,
    input  logic                 r_ready_i,
    input  logic [IdWidth-1:0]   r_id_i,
    input  logic                 r_last_i,
    input  logic [CntWidth-1:0]  budget_i,
    input  logic                 reset_clear_i,
    output logic                 full_o,
    output logic                 reset_req_o,
    output logic                 irq_o,
    output logic [3:0]           irq_cause_o,
    output logic [IdWidth-1:0]   irq_id_o,
    output logic [AddrWidth-1:0] irq_addr_o,
    output logic [CntWidth-1:0]  latency_o,
    output logic                 latency_valid_o
);

    localparam int IDX_W  = (MaxRdTxns > 1) ? $clog2(MaxRdTxns) : 1;
    localparam int RANK_W = $clog2(MaxRdTxns) + 1;
    localparam int PROD_W = CntWidth + 9;
    localparam logic [CntWidth-1:0] CNT_MAX = '1;

    // Slot state
    logic [MaxRdTxns-1:0] busy_q, busy_d;
    logic [IdWidth-1:0]   id_q      [MaxRdTxns];
    logic [IdWidth-1:0]   id_d      [MaxRdTxns];
    logic [AddrWidth-1:0] addr_q    [MaxRdTxns];
    logic [AddrWidth-1:0] addr_d    [MaxRdTxns];
    logic [7:0]           beats_q   [MaxRdTxns];
    logic [7:0]           beats_d   [MaxRdTxns];
    logic [RANK_W-1:0]    rank_q    [MaxRdTxns];
    logic [RANK_W-1:0]    rank_d    [MaxRdTxns];
    logic [CntWidth-1:0]  budget_q  [MaxRdTxns];
    logic [CntWidth-1:0]  budget_d  [MaxRdTxns];
    logic [CntWidth-1:0]  elapsed_q [MaxRdTxns];
    logic [CntWidth-1:0]  elapsed_d [MaxRdTxns];

    // Response / capture state
    logic                 reset_req_q, reset_req_d;
    logic                 irq_q, irq_d;
    logic [3:0]           cause_q, cause_d;
    logic [IdWidth-1:0]   irq_id_q, irq_id_d;
    logic [AddrWidth-1:0] irq_addr_q, irq_addr_d;
    logic [CntWidth-1:0]  lat_q, lat_d;
    logic                 lat_vld_q, lat_vld_d;

    // Combinational decode
    logic                 full;
    logic                 ar_hs, r_hs;
    logic                 head_found;
    logic [IDX_W-1:0]     head_idx;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 to_found;
    logic [IDX_W-1:0]     to_idx;
    logic [MaxRdTxns-1:0] timeout;
    logic [RANK_W-1:0]    same_cnt;
    logic [RANK_W-1:0]    alloc_rank;
    logic [8:0]           len_p1;
    logic [PROD_W-1:0]    prod;
    logic [CntWidth-1:0]  load_budget;
    logic                 alloc, overflow, unwanted, retire, beat_dec, last_err;
    logic                 err;

    always_comb begin
        full  = &busy_q;
        ar_hs = ar_valid_i && ar_ready_i && !reset_req_q;
        r_hs  = r_valid_i && r_ready_i && !reset_req_q;

        // Descending scans so the lowest matching index wins.
        head_found = 1'b0;
        head_idx   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        same_cnt   = '0;
        for (int i = MaxRdTxns - 1; i >= 0; i--) begin
            if (busy_q[i] && id_q[i] == r_id_i && rank_q[i] == '0) begin
                head_found = 1'b1;
                head_idx   = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy_q[i] && id_q[i] == ar_id_i) begin
                same_cnt = same_cnt + RANK_W'(1);
            end
        end

        unwanted = r_hs && !head_found;
        retire   = r_hs && head_found && beats_q[head_idx] == 8'd0 && r_last_i;
        beat_dec = r_hs && head_found && beats_q[head_idx] != 8'd0 && !r_last_i;
        last_err = r_hs && head_found && !retire && !beat_dec;

        to_found = 1'b0;
        to_idx   = '0;
        for (int i = MaxRdTxns - 1; i >= 0; i--) begin
            timeout[i] = busy_q[i] && budget_q[i] == '0
                         && !(retire && head_idx == IDX_W'(i));
            if (timeout[i]) begin
                to_found = 1'b1;
                to_idx   = IDX_W'(i);
            end
        end

        overflow = ar_hs && full;
        alloc    = ar_hs && !full && free_found;
        err      = overflow || unwanted || last_err || to_found;

        // A same-ID retire in this cycle frees one place in the ordering queue.
        alloc_rank = same_cnt;
        if (retire && r_id_i == ar_id_i) begin
            alloc_rank = same_cnt - RANK_W'(1);
        end

        len_p1      = {1'b0, ar_len_i} + 9'd1;
        prod        = {9'd0, budget_i} * {{CntWidth{1'b0}}, len_p1};
        load_budget = (|prod[PROD_W-1:CntWidth]) ? CNT_MAX : prod[CntWidth-1:0];
    end

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < MaxRdTxns; i++) begin
            id_d[i]      = id_q[i];
            addr_d[i]    = addr_q[i];
            beats_d[i]   = beats_q[i];
            rank_d[i]    = rank_q[i];
            budget_d[i]  = budget_q[i];
            elapsed_d[i] = elapsed_q[i];

            if (busy_q[i]) begin
                if (budget_q[i] != '0) begin
                    budget_d[i] = budget_q[i] - CntWidth'(1);
                end
                if (elapsed_q[i] != CNT_MAX) begin
                    elapsed_d[i] = elapsed_q[i] + CntWidth'(1);
                end
                if (head_idx == IDX_W'(i)) begin
                    if (retire) begin
                        busy_d[i] = 1'b0;
                    end else if (beat_dec) begin
                        beats_d[i] = beats_q[i] - 8'd1;
                    end
                end else if (retire && id_q[i] == r_id_i) begin
                    rank_d[i] = rank_q[i] - RANK_W'(1);
                end
            end

            if (alloc && free_idx == IDX_W'(i)) begin
                busy_d[i]    = 1'b1;
                id_d[i]      = ar_id_i;
                addr_d[i]    = ar_addr_i;
                beats_d[i]   = ar_len_i;
                rank_d[i]    = alloc_rank;
                budget_d[i]  = load_budget;
                elapsed_d[i] = '0;
            end
        end
        if (err) begin
            busy_d = '0;
        end
    end

    always_comb begin
        irq_d       = err;
        cause_d     = cause_q;
        irq_id_d    = irq_id_q;
        irq_addr_d  = irq_addr_q;
        reset_req_d = reset_req_q;
        lat_vld_d   = retire;
        lat_d       = lat_q;

        if (err) begin
            cause_d     = {overflow, last_err, unwanted, to_found};
            reset_req_d = 1'b1;
            if (to_found) begin
                irq_id_d   = id_q[to_idx];
                irq_addr_d = addr_q[to_idx];
            end else if (unwanted || last_err) begin
                irq_id_d   = r_id_i;
                irq_addr_d = last_err ? addr_q[head_idx] : '0;
            end else begin
                irq_id_d   = ar_id_i;
                irq_addr_d = '0;
            end
        end else if (reset_clear_i) begin
            reset_req_d = 1'b0;
        end

        if (retire) begin
            lat_d = (elapsed_q[head_idx] == CNT_MAX) ? CNT_MAX
                                                     : elapsed_q[head_idx] + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q      <= '0;
            reset_req_q <= 1'b0;
            irq_q       <= 1'b0;
            cause_q     <= '0;
            irq_id_q    <= '0;
            irq_addr_q  <= '0;
            lat_q       <= '0;
            lat_vld_q   <= 1'b0;
            for (int i = 0; i < MaxRdTxns; i++) begin
                id_q[i]      <= '0;
                addr_q[i]    <= '0;
                beats_q[i]   <= '0;
                rank_q[i]    <= '0;
                budget_q[i]  <= '0;
                elapsed_q[i] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            reset_req_q <= reset_req_d;
            irq_q       <= irq_d;
            cause_q     <= cause_d;
            irq_id_q    <= irq_id_d;
            irq_addr_q  <= irq_addr_d;
            lat_q       <= lat_d;
            lat_vld_q   <= lat_vld_d;
            for (int i = 0; i < MaxRdTxns; i++) begin
                id_q[i]      <= id_d[i];
                addr_q[i]    <= addr_d[i];
                beats_q[i]   <= beats_d[i];
                rank_q[i]    <= rank_d[i];
                budget_q[i]  <= budget_d[i];
                elapsed_q[i] <= elapsed_d[i];
            end
        end
    end

    assign full_o          = full;
    assign reset_req_o     = reset_req_q;
    assign irq_o           = irq_q;
    assign irq_cause_o     = cause_q;
    assign irq_id_o        = irq_id_q;
    assign irq_addr_o      = irq_addr_q;
    assign latency_o       = lat_q;
    assign latency_valid_o = lat_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_read_guard.sv
// +--------------------------------------------------------------------------+
// | tb_read_guard : directed self-checking bench for read_guard              |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_read_guard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ar_valid_i, ar_ready_i;
    logic [3:0]  ar_id_i;
    logic [31:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic        r_valid_i, r_ready_i;
    logic [3:0]  r_id_i;
    logic        r_last_i;
    logic [15:0] budget_i;
    logic        reset_clear_i;
    logic        full_o, reset_req_o, irq_o, latency_valid_o;
    logic [3:0]  irq_cause_o;
    logic [3:0]  irq_id_o;
    logic [31:0] irq_addr_o;
    logic [15:0] latency_o;

    int total = 0;
    int bad   = 0;

    read_guard dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_id_i(ar_id_i),
        .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_id_i(r_id_i),
        .r_last_i(r_last_i), .budget_i(budget_i), .reset_clear_i(reset_clear_i),
        .full_o(full_o), .reset_req_o(reset_req_o), .irq_o(irq_o),
        .irq_cause_o(irq_cause_o), .irq_id_o(irq_id_o), .irq_addr_o(irq_addr_o),
        .latency_o(latency_o), .latency_valid_o(latency_valid_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the edge; outputs are read there too.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        ar_valid_i = 0; ar_ready_i = 1; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0;
        r_valid_i = 0; r_ready_i = 1; r_id_i = 0; r_last_i = 0;
        budget_i = 0; reset_clear_i = 0;
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [15:0] bud);
        ar_valid_i = 1; ar_id_i = id; ar_addr_i = addr; ar_len_i = len; budget_i = bud;
    endtask

    task automatic clear_req();
        idle();
        reset_clear_i = 1;
        step();
        reset_clear_i = 0;
        step();
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1;
        step(); step();
        rst_i = 0;
        step();
        total++;
        if ({full_o, reset_req_o, irq_o, irq_cause_o, irq_id_o, irq_addr_o,
             latency_o, latency_valid_o} !== 59'd0) begin
            bad++;
            $display("FAIL reset_outputs: got full=%b req=%b irq=%b cause=%b id=%0h addr=%0h lat=%0d lv=%b required all 0",
                     full_o, reset_req_o, irq_o, irq_cause_o, irq_id_o, irq_addr_o, latency_o, latency_valid_o);
        end
    endtask

    task automatic test_latency();
        set_ar(4'd2, 32'h0000_1000, 8'd3, 16'd10);
        step();                                  // edge 0
        idle();
        repeat (4) step();                       // edges 1..4
        for (int b = 0; b < 4; b++) begin        // edges 5..8
            r_valid_i = 1; r_id_i = 4'd2; r_last_i = (b == 3);
            step();
        end
        idle();
        total++;
        if ({latency_valid_o, latency_o} !== {1'b1, 16'd8}) begin
            bad++;
            $display("FAIL latency_basic: got vld=%b lat=%0d required vld=1 lat=8", latency_valid_o, latency_o);
        end
        total++;
        if ({irq_o, reset_req_o} !== 2'b00) begin
            bad++;
            $display("FAIL latency_no_irq: got irq=%b req=%b required 0 0", irq_o, reset_req_o);
        end
        step();
        total++;
        if (latency_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL latency_pulse: got vld=%b required 0", latency_valid_o);
        end
    endtask

    task automatic test_timeout();
        set_ar(4'd1, 32'hABCD_0010, 8'd0, 16'd4);
        step();                                  // edge 0
        idle();
        repeat (4) step();                       // edges 1..4
        total++;
        if (irq_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: got irq=%b required 0", irq_o);
        end
        step();                                  // edge 5: timeout detected
        total++;
        if ({irq_o, reset_req_o, irq_cause_o, irq_id_o, irq_addr_o} !== {2'b11, 4'b0001, 4'd1, 32'hABCD_0010}) begin
            bad++;
            $display("FAIL timeout_irq: got irq=%b req=%b cause=%b id=%0h addr=%0h required 1 1 0001 1 abcd0010",
                     irq_o, reset_req_o, irq_cause_o, irq_id_o, irq_addr_o);
        end
        // While the request is pending, further errors are ignored.
        r_valid_i = 1; r_id_i = 4'd9; r_last_i = 1;
        step();
        idle();
        step();
        total++;
        if ({irq_o, reset_req_o, irq_cause_o, irq_id_o} !== {2'b01, 4'b0001, 4'd1}) begin
            bad++;
            $display("FAIL timeout_hold: got irq=%b req=%b cause=%b id=%0h required 0 1 0001 1",
                     irq_o, reset_req_o, irq_cause_o, irq_id_o);
        end
        clear_req();
        total++;
        if (reset_req_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear: got req=%b required 0", reset_req_o);
        end
    endtask

    task automatic test_zero_budget();
        set_ar(4'd4, 32'h0000_0400, 8'd0, 16'd0);
        step();                                  // edge 0: loads 0
        idle();
        step();                                  // edge 1: timeout detected
        total++;
        if ({irq_o, irq_cause_o, irq_id_o, irq_addr_o} !== {1'b1, 4'b0001, 4'd4, 32'h0000_0400}) begin
            bad++;
            $display("FAIL zero_budget: got irq=%b cause=%b id=%0h addr=%0h required 1 0001 4 400",
                     irq_o, irq_cause_o, irq_id_o, irq_addr_o);
        end
        clear_req();
    endtask

    task automatic test_unwanted();
        r_valid_i = 1; r_id_i = 4'd7; r_last_i = 1;
        step();
        idle();
        total++;
        if ({irq_o, irq_cause_o, irq_id_o, irq_addr_o} !== {1'b1, 4'b0010, 4'd7, 32'd0}) begin
            bad++;
            $display("FAIL unwanted: got irq=%b cause=%b id=%0h addr=%0h required 1 0010 7 0",
                     irq_o, irq_cause_o, irq_id_o, irq_addr_o);
        end
        clear_req();
    endtask

    task automatic test_last_err();
        set_ar(4'd3, 32'h2000_0040, 8'd1, 16'd20);
        step();
        idle();
        step();
        r_valid_i = 1; r_id_i = 4'd3; r_last_i = 1;
        step();
        idle();
        total++;
        if ({irq_o, irq_cause_o, irq_id_o, irq_addr_o} !== {1'b1, 4'b0100, 4'd3, 32'h2000_0040}) begin
            bad++;
            $display("FAIL last_err: got irq=%b cause=%b id=%0h addr=%0h required 1 0100 3 20000040",
                     irq_o, irq_cause_o, irq_id_o, irq_addr_o);
        end
        clear_req();
    endtask

    task automatic test_same_id();
        set_ar(4'd5, 32'h0000_5000, 8'd0, 16'd20);
        step();                                  // edge 0
        set_ar(4'd5, 32'h0000_5100, 8'd2, 16'd20);
        step();                                  // edge 1
        idle();
        r_valid_i = 1; r_id_i = 4'd5; r_last_i = 1;
        step();                                  // edge 2: first slot retires
        total++;
        if ({latency_valid_o, latency_o, irq_o} !== {1'b1, 16'd2, 1'b0}) begin
            bad++;
            $display("FAIL same_id_first: got vld=%b lat=%0d irq=%b required 1 2 0", latency_valid_o, latency_o, irq_o);
        end
        for (int b = 0; b < 3; b++) begin        // edges 3..5
            r_valid_i = 1; r_id_i = 4'd5; r_last_i = (b == 2);
            step();
        end
        idle();
        total++;
        if ({latency_valid_o, latency_o} !== {1'b1, 16'd4}) begin
            bad++;
            $display("FAIL same_id_second: got vld=%b lat=%0d required 1 4", latency_valid_o, latency_o);
        end
        total++;
        if ({irq_o, reset_req_o, full_o} !== 3'b000) begin
            bad++;
            $display("FAIL same_id_clean: got irq=%b req=%b full=%b required 0 0 0", irq_o, reset_req_o, full_o);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 4; k++) begin
            set_ar(4'(k), 32'h0000_6000 + 32'(k), 8'd0, 16'd50);
            step();
        end
        idle();
        total++;
        if (full_o !== 1'b1) begin
            bad++;
            $display("FAIL overflow_full: got full=%b required 1", full_o);
        end
        set_ar(4'hA, 32'h0000_7000, 8'd0, 16'd50);
        step();
        idle();
        total++;
        if ({irq_o, irq_cause_o, irq_id_o, irq_addr_o} !== {1'b1, 4'b1000, 4'hA, 32'd0}) begin
            bad++;
            $display("FAIL overflow: got irq=%b cause=%b id=%0h addr=%0h required 1 1000 a 0",
                     irq_o, irq_cause_o, irq_id_o, irq_addr_o);
        end
        total++;
        if (full_o !== 1'b0) begin
            bad++;
            $display("FAIL overflow_cleared: got full=%b required 0", full_o);
        end
        clear_req();
        for (int k = 0; k < 4; k++) begin
            set_ar(4'(k), 32'h0000_6000 + 32'(k), 8'd0, 16'd50);
            step();
        end
        set_ar(4'hB, 32'h0000_7100, 8'd0, 16'd50);
        r_valid_i = 1; r_id_i = 4'd0; r_last_i = 1;
        step();
        idle();
        total++;
        if ({irq_o, irq_cause_o, irq_id_o, irq_addr_o} !== {1'b1, 4'b1000, 4'hB, 32'd0}) begin
            bad++;
            $display("FAIL overflow_retire: got irq=%b cause=%b id=%0h addr=%0h required 1 1000 b 0",
                     irq_o, irq_cause_o, irq_id_o, irq_addr_o);
        end
        clear_req();
    endtask

    initial begin
        rst_i = 1;
        idle();
        test_reset();
        test_latency();
        test_timeout();
        test_zero_budget();
        test_unwanted();
        test_last_err();
        test_same_id();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
